// File: rtl/timer_scan_display_if.sv
// Bundle between the countdown timer and the scanned 2-digit display.
// master: drives TimerL/TimerR/Start, reads Seg/Sel/Done/DonePulse.
// slave : the display block; reads the timer digits, drives the display.
interface timer_scan_display_if;
   logic [3:0] TimerL;
   logic [3:0] TimerR;
   logic       Start;
   logic [7:0] Seg;
   logic [1:0] Sel;
   logic       Done;
   logic       DonePulse;

   modport master (
      output TimerL, TimerR, Start,
      input  Seg, Sel, Done, DonePulse
   );

   modport slave (
      input  TimerL, TimerR, Start,
      output Seg, Sel, Done, DonePulse
   );
endinterface

// File: rtl/timer_scan_display.sv
// Scanned 2-digit active-low 7-seg driver for the countdown timer.
// Ports: CLK, RST (sync, active-high), bus (slave):
//   TimerL/TimerR/Start in (async to CLK), Seg/Sel out (active-low),
//   Done level and DonePulse one-shot on expiry.
module timer_scan_display #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned GUARD     = 8,
   parameter int unsigned BLINK_DIV = 12500000,
   parameter int unsigned CNT_W     = 25
) (
   input  logic CLK,
   input  logic RST,
   timer_scan_display_if.slave bus
);
   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LEN  = CNT_W'(GUARD);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

   typedef enum logic {
      UNITS = 1'b0,
      TENS  = 1'b1
   } slot_e;

   logic [7:0]       s1_q, s2_q, latch_q;
   logic             st1_q, st2_q;
   logic             done_q, pulse_q;
   logic [CNT_W-1:0] cnt_q, bcnt_q;
   slot_e            slot_q;
   logic             blink_on_q;
   logic [7:0]       seg_q, seg_d;
   logic [1:0]       sel_q, sel_d;
   logic             exp_d;
   logic [3:0]       digit;
   logic             blank;

   function automatic logic [7:0] seg_enc(input logic [3:0] v);
      logic [7:0] r;
      unique case (v)
         4'd0:    r = 8'hC0;
         4'd1:    r = 8'hF9;
         4'd2:    r = 8'hA4;
         4'd3:    r = 8'hB0;
         4'd4:    r = 8'h99;
         4'd5:    r = 8'h92;
         4'd6:    r = 8'h82;
         4'd7:    r = 8'hF8;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h90;
         default: r = 8'hBF;
      endcase
      return r;
   endfunction

   // Latched value 4'hF on both digits can never look like "00",
   // so reset cannot produce a false expiry.
   assign exp_d = (latch_q == 8'h00) && !st2_q;

   always_comb begin
      digit = (slot_q == UNITS) ? latch_q[3:0] : latch_q[7:4];
      sel_d = 2'b11;
      seg_d = 8'hFF;
      blank = 1'b0;
      if (done_q && !blink_on_q)
         blank = 1'b1;
      if (slot_q == TENS && latch_q[7:4] == 4'd0 && !done_q)
         blank = 1'b1;
      if (cnt_q >= GUARD_LEN) begin
         sel_d = (slot_q == UNITS) ? 2'b10 : 2'b01;
         if (!blank)
            seg_d = seg_enc(digit);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q       <= 8'hFF;
         s2_q       <= 8'hFF;
         latch_q    <= 8'hFF;
         st1_q      <= 1'b1;
         st2_q      <= 1'b1;
         done_q     <= 1'b0;
         pulse_q    <= 1'b0;
         cnt_q      <= '0;
         slot_q     <= UNITS;
         bcnt_q     <= '0;
         blink_on_q <= 1'b1;
         seg_q      <= 8'hFF;
         sel_q      <= 2'b11;
      end else begin
         s1_q <= {bus.TimerL, bus.TimerR};
         s2_q <= s1_q;
         // Two equal consecutive samples filter out mid-update skew.
         if (s1_q == s2_q)
            latch_q <= s2_q;
         st1_q   <= bus.Start;
         st2_q   <= st1_q;
         done_q  <= exp_d;
         pulse_q <= exp_d && !done_q;

         if (cnt_q == SCAN_LAST) begin
            cnt_q  <= '0;
            slot_q <= (slot_q == UNITS) ? TENS : UNITS;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end

         // Held at 0/ON while idle, so each expiry starts visible.
         if (!done_q) begin
            bcnt_q     <= '0;
            blink_on_q <= 1'b1;
         end else if (bcnt_q == BLINK_LAST) begin
            bcnt_q     <= '0;
            blink_on_q <= !blink_on_q;
         end else begin
            bcnt_q <= bcnt_q + 1'b1;
         end

         seg_q <= seg_d;
         sel_q <= sel_d;
      end
   end

   assign bus.Seg       = seg_q;
   assign bus.Sel       = sel_q;
   assign bus.Done      = done_q;
   assign bus.DonePulse = pulse_q;
endmodule
